// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path.
package hdlc_pkg;

    typedef enum logic [1:0] {HUNT, OPEN, FRAME} rx_deframe_state_t;

    localparam logic [7:0] HDLC_FLAG       = 8'h7E;
    localparam int         HDLC_STUFF_ONES = 5;

endpackage

// File: rtl/hdlc_rx_unstuff.sv
// Zero-unstuffing and LSB-first octet assembly for eligible candidate bits.
module hdlc_rx_unstuff
    import hdlc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cand,
    input  logic       eligible,
    input  logic       clear,
    output logic       emit,
    output logic       partial,
    output logic       rxd,
    output logic       new_bit,
    output logic       new_byte,
    output logic       zero_det,
    output logic [7:0] data
);

    logic [2:0] ones_out;
    logic [2:0] bitcnt;
    logic [2:0] bitcnt_inc;
    logic       drop;

    assign drop       = eligible && !cand && (ones_out == 3'(HDLC_STUFF_ONES));
    assign emit       = eligible && !drop;
    assign bitcnt_inc = bitcnt + 3'd1;
    // Octet alignment as it stands after this cycle's emission, for the closing-flag check.
    assign partial    = emit ? (bitcnt_inc != 3'd0) : (bitcnt != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_out <= '0;
            bitcnt   <= '0;
            rxd      <= 1'b0;
            new_bit  <= 1'b0;
            new_byte <= 1'b0;
            zero_det <= 1'b0;
            data     <= '0;
        end else if (!en) begin
            new_bit  <= 1'b0;
            new_byte <= 1'b0;
            zero_det <= 1'b0;
        end else begin
            new_bit  <= emit;
            new_byte <= emit && (bitcnt_inc == 3'd0);
            zero_det <= drop;
            if (emit) begin
                rxd  <= cand;
                data <= {cand, data[7:1]};
            end
            if (clear) begin
                ones_out <= '0;
                bitcnt   <= '0;
            end else begin
                if (drop)
                    ones_out <= '0;
                else if (emit)
                    ones_out <= cand ? ((ones_out == 3'd7) ? 3'd7 : ones_out + 3'd1) : 3'd0;
                if (emit)
                    bitcnt <= bitcnt_inc;
            end
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive front end: flag hunt, abort detection, 8-bit delay window feeding the unstuffer.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter logic [7:0] FLAG       = HDLC_FLAG,
    parameter int         ABORT_ONES = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic       Rx_ValidFrame,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_StartZeroDetect,
    output logic       ZeroDetect,
    output logic       RxD,
    output logic       Rx_NewBit,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);

    rx_deframe_state_t state, state_nxt;
    logic [7:0] win, win_nxt;
    logic [3:0] fill, ones_in, ones_in_nxt;
    logic       flag_hit, abort_hit, full;
    logic       elig, clr, emit, partial;
    logic       start, eof, ferr, vf_nxt;

    assign win_nxt     = {Rx, win[7:1]};
    assign ones_in_nxt = Rx ? ((ones_in == 4'd15) ? 4'd15 : ones_in + 4'd1) : 4'd0;
    assign flag_hit    = (win_nxt == FLAG);
    // Fires only on the step into ABORT_ONES; saturation keeps idle-line ones quiet afterwards.
    assign abort_hit   = (state != HUNT) && Rx && (ones_in == 4'(ABORT_ONES - 1));
    assign full        = (fill == 4'd8);
    // A flag while still OPEN means an empty frame, so its exiting candidate is not a data bit.
    assign elig        = full && !abort_hit &&
                         ((state == FRAME) || (state == OPEN && !flag_hit));

    always_comb begin
        state_nxt = state;
        vf_nxt    = Rx_ValidFrame;
        clr       = 1'b0;
        start     = 1'b0;
        eof       = 1'b0;
        ferr      = 1'b0;
        unique case (state)
            HUNT: begin
                if (flag_hit) begin
                    clr       = 1'b1;
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (abort_hit) begin
                    clr       = 1'b1;
                    state_nxt = HUNT;
                end else if (flag_hit) begin
                    clr = 1'b1;
                end else if (emit) begin
                    start     = 1'b1;
                    vf_nxt    = 1'b1;
                    state_nxt = FRAME;
                end
            end
            FRAME: begin
                if (abort_hit) begin
                    clr       = 1'b1;
                    vf_nxt    = 1'b0;
                    state_nxt = HUNT;
                end else if (flag_hit) begin
                    clr       = 1'b1;
                    eof       = 1'b1;
                    ferr      = partial;
                    vf_nxt    = 1'b0;
                    state_nxt = OPEN;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= HUNT;
            win           <= '0;
            fill          <= '0;
            ones_in       <= '0;
            Rx_ValidFrame <= 1'b0;
        end else if (RxEN) begin
            state         <= state_nxt;
            win           <= win_nxt;
            ones_in       <= ones_in_nxt;
            fill          <= clr ? 4'd0 : (full ? 4'd8 : fill + 4'd1);
            Rx_ValidFrame <= vf_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Rx_FlagDetect      <= 1'b0;
            Rx_AbortDetect     <= 1'b0;
            Rx_StartZeroDetect <= 1'b0;
            Rx_EoF             <= 1'b0;
            Rx_FrameError      <= 1'b0;
        end else begin
            Rx_FlagDetect      <= RxEN && flag_hit;
            Rx_AbortDetect     <= RxEN && abort_hit;
            Rx_StartZeroDetect <= RxEN && start;
            Rx_EoF             <= RxEN && eof;
            Rx_FrameError      <= RxEN && ferr;
        end
    end

    hdlc_rx_unstuff u_unstuff (
        .clk      (Clk),
        .rst_n    (Rst),
        .en       (RxEN),
        .cand     (win[0]),
        .eligible (elig),
        .clear    (clr),
        .emit     (emit),
        .partial  (partial),
        .rxd      (RxD),
        .new_bit  (Rx_NewBit),
        .new_byte (Rx_NewByte),
        .zero_det (ZeroDetect),
        .data     (Rx_Data)
    );

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Randomized and directed bench; reference model parses the line stream into flag-delimited frames.
module tb_hdlc_rx_deframer;

    logic       Clk = 1'b0, Rst = 1'b0, RxEN = 1'b0, Rx = 1'b0;
    logic       Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect, Rx_StartZeroDetect;
    logic       ZeroDetect, RxD, Rx_NewBit, Rx_NewByte, Rx_EoF, Rx_FrameError;
    logic [7:0] Rx_Data;

    hdlc_rx_deframer dut (
        .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_StartZeroDetect(Rx_StartZeroDetect),
        .ZeroDetect(ZeroDetect), .RxD(RxD), .Rx_NewBit(Rx_NewBit), .Rx_NewByte(Rx_NewByte),
        .Rx_Data(Rx_Data), .Rx_EoF(Rx_EoF), .Rx_FrameError(Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {flag, abort, start, zero, newbit, newbyte, eof, ferr, validframe}
    function automatic logic [8:0] obs();
        return {Rx_FlagDetect, Rx_AbortDetect, Rx_StartZeroDetect, ZeroDetect,
                Rx_NewBit, Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_ValidFrame};
    endfunction

    bit         q[$];
    logic [8:0] exp_p[];
    bit         exp_rxd[];
    logic [7:0] exp_dat[];
    logic [7:0] mdata;
    int         stuff_ones;
    int         nflag, nabort, nstart, nzero, neof, nferr, nbyte;
    logic [7:0] blog[8];

    function automatic bit gb(input int i);
        return (i < 0 || i >= q.size()) ? 1'b0 : q[i];
    endfunction

    function automatic bit is_flag(input int i);
        bit ok = (gb(i - 7) == 1'b0) && (gb(i) == 1'b0);
        for (int k = i - 6; k <= i - 1; k++) ok &= (gb(k) == 1'b1);
        return ok;
    endfunction

    // kind: 0 abort at c, 1 closing flag at c, 2 stream ended (n cycles)
    task automatic close_seg(input int first, input int last, input int c, input int kind, input int n);
        int ones = 0, cnt = 0, emitted = 0, st = -1, stop;
        for (int k = first; k <= last; k++) begin
            if (q[k] == 1'b0 && ones == 5) begin
                exp_p[k + 8][5] = 1'b1;
                ones = 0;
            end else begin
                exp_p[k + 8][4] = 1'b1;
                exp_rxd[k + 8]  = q[k];
                mdata = {q[k], mdata[7:1]};
                if (emitted == 0) begin
                    exp_p[k + 8][6] = 1'b1;
                    st = k + 8;
                end
                emitted++;
                cnt = (cnt + 1) % 8;
                if (cnt == 0) begin
                    exp_p[k + 8][3] = 1'b1;
                    exp_dat[k + 8]  = mdata;
                end
                ones = q[k] ? ones + 1 : 0;
            end
        end
        if (emitted > 0) begin
            stop = (kind == 2) ? n - 1 : c - 1;
            for (int j = st; j <= stop; j++) exp_p[j][0] = 1'b1;
            if (kind == 1) begin
                exp_p[c][2] = 1'b1;
                exp_p[c][1] = (cnt != 0);
            end
        end
    endtask

    task automatic build_model();
        int n = q.size(), r = 0, so = -1;
        bit hunting = 1'b1;
        exp_p = new[n]; exp_rxd = new[n]; exp_dat = new[n];
        for (int i = 0; i < n; i++) begin
            exp_p[i] = '0; exp_rxd[i] = 1'b0; exp_dat[i] = '0;
        end
        for (int i = 0; i < n; i++) begin
            r = q[i] ? ((r < 15) ? r + 1 : 15) : 0;
            if (!hunting && q[i] && r == 7) begin
                exp_p[i][7] = 1'b1;
                close_seg(so + 1, i - 9, i, 0, n);
                hunting = 1'b1;
            end else if (is_flag(i)) begin
                exp_p[i][8] = 1'b1;
                if (!hunting) close_seg(so + 1, i - 8, i, 1, n);
                so = i;
                hunting = 1'b0;
            end
        end
        if (!hunting) close_seg(so + 1, n - 9, n, 2, n);
    endtask

    task automatic push_flag();
        logic [7:0] f = 8'h7E;
        for (int i = 0; i < 8; i++) q.push_back(f[i]);
        stuff_ones = 0;
    endtask

    task automatic push_dbit(input bit b);
        q.push_back(b);
        if (b) begin
            stuff_ones++;
            if (stuff_ones == 5) begin
                q.push_back(1'b0);
                stuff_ones = 0;
            end
        end else stuff_ones = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) push_dbit(b[i]);
    endtask

    task automatic clr_cnt();
        nflag = 0; nabort = 0; nstart = 0; nzero = 0; neof = 0; nferr = 0; nbyte = 0;
        for (int i = 0; i < 8; i++) blog[i] = '0;
    endtask

    task automatic do_reset();
        RxEN = 1'b0; Rx = 1'b0; Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        mdata = '0;
        q.delete();
        clr_cnt();
    endtask

    // gap_mode: 0 none, 1 one idle cycle before every bit, 2 random idle cycles
    task automatic run_stream(input int gap_mode);
        logic [8:0] o;
        bit pvf = 1'b0;
        int gaps;
        build_model();
        for (int i = 0; i < q.size(); i++) begin
            gaps = (gap_mode == 1) ? 1 :
                   (gap_mode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            repeat (gaps) begin
                RxEN = 1'b0; Rx = 1'($urandom);
                @(posedge Clk); #1;
                o = obs();
                chk("gap_pulses", {23'd0, o[8:1]}, 32'd0);
                chk("gap_vf", {31'd0, o[0]}, {31'd0, pvf});
            end
            RxEN = 1'b1; Rx = q[i];
            @(posedge Clk); #1;
            o = obs();
            chk($sformatf("cyc%0d", i), {23'd0, o}, {23'd0, exp_p[i]});
            if (exp_p[i][4]) chk($sformatf("rxd%0d", i), {31'd0, RxD}, {31'd0, exp_rxd[i]});
            if (exp_p[i][3]) chk($sformatf("data%0d", i), {24'd0, Rx_Data}, {24'd0, exp_dat[i]});
            pvf = exp_p[i][0];
            nflag += o[8]; nabort += o[7]; nstart += o[6]; nzero += o[5];
            neof += o[2]; nferr += o[1];
            if (o[3]) begin
                blog[nbyte % 8] = Rx_Data;
                nbyte++;
            end
        end
        RxEN = 1'b0;
    endtask

    initial begin
        bit need_open;
        clr_cnt();
        #2;
        chk("reset_state", {21'd0, obs(), RxD, Rx_Data[0]}, 32'd0);
        chk("reset_data", {24'd0, Rx_Data}, 32'd0);

        // stuffed 0x3F
        do_reset();
        push_flag(); push_byte(8'h3F); push_flag();
        run_stream(0);
        chk("s1_zero", nzero, 1); chk("s1_nbyte", nbyte, 1); chk("s1_byte", blog[0], 8'h3F);
        chk("s1_eof", neof, 1); chk("s1_ferr", nferr, 0);

        // shared/back-to-back flags
        do_reset();
        push_flag(); push_flag(); push_flag(); push_byte(8'hA5); push_byte(8'h5A); push_flag();
        run_stream(0);
        chk("s2_flag", nflag, 4); chk("s2_nbyte", nbyte, 2);
        chk("s2_b0", blog[0], 8'hA5); chk("s2_b1", blog[1], 8'h5A); chk("s2_start", nstart, 1);

        // abort, then recovery
        do_reset();
        push_flag(); push_byte(8'hC3);
        repeat (8) q.push_back(1'b1);
        push_flag(); push_byte(8'h11); push_flag();
        run_stream(0);
        chk("s3_abort", nabort, 1); chk("s3_eof", neof, 1);
        chk("s3_nbyte", nbyte, 1); chk("s3_byte", blog[0], 8'h11);

        // misaligned frame
        do_reset();
        push_flag(); push_byte(8'h81); push_dbit(1'b0); push_dbit(1'b1); push_dbit(1'b0); push_flag();
        run_stream(0);
        chk("s4_nbyte", nbyte, 1); chk("s4_byte", blog[0], 8'h81);
        chk("s4_eof", neof, 1); chk("s4_ferr", nferr, 1);

        // RxEN toggling with flag-like data
        do_reset();
        push_flag(); push_byte(8'h7E); push_flag();
        run_stream(1);
        chk("s5_flag", nflag, 2); chk("s5_nbyte", nbyte, 1); chk("s5_byte", blog[0], 8'h7E);
        chk("s5_zero", nzero, 1);

        // reset mid-byte
        do_reset();
        push_flag();
        for (int i = 0; i < 11; i++) push_dbit(1'($urandom));
        run_stream(0);
        chk("s6_vf_before", {31'd0, Rx_ValidFrame}, 32'd1);
        @(posedge Clk); #2 Rst = 1'b0; #1;
        chk("s6_rst_out", {22'd0, obs(), RxD}, 32'd0);
        chk("s6_rst_data", {24'd0, Rx_Data}, 32'd0);
        do_reset();
        push_flag(); push_byte(8'h42); push_flag();
        run_stream(0);
        chk("s6_nbyte", nbyte, 1); chk("s6_byte", blog[0], 8'h42); chk("s6_eof", neof, 1);

        // random frames, aborts, odd lengths and enable gaps
        do_reset();
        repeat ($urandom_range(0, 12)) q.push_back(1'b1);
        need_open = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if (need_open) push_flag();
            repeat ($urandom_range(1, 4)) push_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 7)) push_dbit(1'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(7, 10)) q.push_back(1'b1);
                need_open = 1'b1;
            end else begin
                push_flag();
                need_open = 1'($urandom_range(0, 1));
            end
        end
        run_stream(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
Serial receive front end of the HDLC controller. It sits between the line input Rx and the Rx byte buffer/FCS logic, and drives the Rx_* byte-level signals the Rx channel consumes. Per enabled cycle it takes one line bit and performs four jobs: hunts for flags, detects aborts, removes stuffed zeros, and assembles LSB-first octets. Frame boundaries (start, end, abort, misalignment) are reported as single-cycle pulses.

Parameters:
FLAG, 8'h7E, flag pattern as it appears in the 8-bit window.
ABORT_ONES, 7, run of consecutive line ones that constitutes an abort.

Ports:
Clk  in  1  system clock, all state on rising edge
Rst  in  1  asynchronous, active-low reset
RxEN  in  1  bit strobe/enable; when 0 all state frozen, all pulse outputs 0
Rx  in  1  serial line bit, sampled when RxEN=1
Rx_ValidFrame  out  1  level: inside a frame (opening flag followed by ≥1 data bit)
Rx_FlagDetect  out  1  pulse: FLAG completed in window
Rx_AbortDetect  out  1  pulse: ABORT_ONES consecutive ones seen while not hunting
Rx_StartZeroDetect  out  1  pulse: first data bit of a frame emitted
ZeroDetect  out  1  pulse: stuffed zero dropped
RxD  out  1  unstuffed data bit, qualified by Rx_NewBit
Rx_NewBit  out  1  pulse: RxD valid
Rx_NewByte  out  1  pulse: Rx_Data holds a complete octet
Rx_Data  out  8  assembled octet, LSB received first
Rx_EoF  out  1  pulse: closing flag ended a valid frame
Rx_FrameError  out  1  pulse with Rx_EoF when bit count mod 8 ≠ 0

Behaviour:
- Reset (Rst=0, async): window=8'h00, fill=0, run counters=0, bitcnt=0, Rx_Data=0, state=HUNT, all outputs 0.
- All updates occur only when RxEN=1. Pulse outputs are registered, last one cycle, and are 0 in any cycle with RxEN=0.
- Window: win <= {Rx, win[7:1]}. The bit shifted out (old win[0]) is the candidate bit.
- fill counts 0..8 bits entered since the last flag or abort, saturating at 8. A candidate is eligible only when fill==8, so flag bits are never emitted.
- Latency: a line bit leaves as RxD 8 enabled cycles after it is sampled, or is dropped.
- Unstuffing:
  - ones_out counts consecutive eligible candidate ones.
  - Eligible candidate 0 with ones_out==5 → dropped, ZeroDetect=1, ones_out=0.
  - Otherwise the candidate is emitted: RxD=bit, Rx_NewBit=1.
- Octet assembly: each emitted bit gives Rx_Data <= {bit, Rx_Data[7:1]} and bitcnt=(bitcnt+1) mod 8. The bit that wraps bitcnt to 0 also raises Rx_NewByte in the same cycle as its Rx_NewBit.
- ones_in counts consecutive line ones on Rx, saturating at 15.
- States:
  - HUNT: no emission. Window==FLAG → FlagDetect, fill=0, go OPEN.
  - OPEN: window==FLAG → FlagDetect, fill=0, stay (back-to-back/shared flags). First emitted bit → Rx_StartZeroDetect, Rx_ValidFrame=1, bitcnt=1, go FRAME.
  - FRAME: window==FLAG → FlagDetect, Rx_EoF; Rx_FrameError if bitcnt≠0; ValidFrame=0; fill=0, bitcnt=0; go OPEN (closing flag may open the next frame).
  - OPEN/FRAME: ones_in reaching ABORT_ONES → Rx_AbortDetect; ValidFrame=0; fill=0, bitcnt=0; go HUNT. No EoF. A partial octet is discarded.
- Priority within one cycle: abort > flag > emission. The candidate exiting in the flag-completing cycle is still emitted if eligible.
- Continuous ones (idle line) keep ones_in saturated. Exactly one AbortDetect is raised per abort event; none is raised in HUNT.

Decomposition:
- hdlc_pkg holds:
  - typedef enum logic [1:0] {HUNT, OPEN, FRAME} rx_deframe_state_t;
  - localparams HDLC_FLAG=8'h7E, HDLC_STUFF_ONES=5.
- One natural sub-module, hdlc_rx_unstuff: owns ones_out, drop/emit, byte assembly and bitcnt. Inputs are candidate bit, eligible and clear.

Test Plan:
- Line 7E, 0x3F, 7E (wire bits 1111101 00 after stuffing) → exactly one ZeroDetect; Rx_NewByte with Rx_Data=0x3F; one Rx_EoF, Rx_FrameError=0.
- Line 7E,7E,7E, 0xA5, 0x5A, 7E → FlagDetect ×4; NewByte 0xA5 then 0x5A; single StartZeroDetect; ValidFrame high from first data bit to closing flag.
- Line 7E, 0xC3, then 8 ones → AbortDetect once; ValidFrame=0; no EoF; following 7E, 0x11, 7E receives 0x11 normally.
- Line 7E, 0x81, three bits 010, 7E → NewByte 0x81, then EoF with Rx_FrameError=1.
- RxEN toggled 1/0 every cycle during frame 7E, 0x7E-stuffed data (wire 011111 0 10), 7E → Rx_Data=0x7E; no false FlagDetect; outputs match the RxEN=1 run bit-for-bit.
- Rst asserted mid-byte (after 3 data bits) → outputs 0 immediately; state HUNT; next 7E, 0x42, 7E yields Rx_Data=0x42.
